// File: rtl/uv_pred_sse_pkg.sv
// ----------------------------------------------------------------------------
// uv_pred_sse_pkg
// Shared definitions for the chroma residual / SSE mode-decision stage:
// default widths, the residual sample width and the one-hot FSM encoding.
// ----------------------------------------------------------------------------
package uv_pred_sse_pkg;

  localparam int BIT_WIDTH_DEF  = 8;   // sample width in bits
  localparam int BLOCK_SIZE_DEF = 8;   // samples per row, rows per plane
  localparam int UV_SIZE_DEF    = 16;  // U rows then V rows
  localparam int SSE_WIDTH_DEF  = 22;  // per-plane SSE accumulator width

  // Signed residual needs one extra bit over the sample width.
  localparam int RESID_WIDTH = BIT_WIDTH_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

endpackage

// File: rtl/uv_pred_sse_if.sv
// ----------------------------------------------------------------------------
// uv_pred_sse_if
// Residual row stream towards the chroma transform.
//   resid_row   : BLOCK_SIZE signed residuals, sample c at [RW*c +: RW]
//   resid_idx   : row index 0..15 (U rows 0-7, V rows 8-15)
//   resid_valid : row/index valid
//   resid_ready : downstream accepts the row
// master = producer (uv_pred_sse), slave = consumer (transform).
// ----------------------------------------------------------------------------
interface uv_pred_sse_if #(
  parameter int BIT_WIDTH  = uv_pred_sse_pkg::BIT_WIDTH_DEF,
  parameter int BLOCK_SIZE = uv_pred_sse_pkg::BLOCK_SIZE_DEF
) ();

  logic [(BIT_WIDTH+1)*BLOCK_SIZE-1:0] resid_row;
  logic [3:0]                          resid_idx;
  logic                                resid_valid;
  logic                                resid_ready;

  modport master (
    output resid_row,
    output resid_idx,
    output resid_valid,
    input  resid_ready
  );

  modport slave (
    input  resid_row,
    input  resid_idx,
    input  resid_valid,
    output resid_ready
  );

endinterface

// File: rtl/uv_row_sse.sv
// ----------------------------------------------------------------------------
// uv_row_sse
// Purely combinational row kernel: residual = src - pred per sample (signed,
// no saturation), row SSE = sum of squared residuals and, when
// UV_PRED_SAD_EN is defined, row SAD = sum of absolute residuals.
//   src_row / pred_row : BLOCK_SIZE unsigned samples, sample c at [BW*c +: BW]
//   resid_row          : BLOCK_SIZE signed residuals, sample c at [RW*c +: RW]
//   row_sse            : unsigned row SSE
//   row_sad            : unsigned row SAD (UV_PRED_SAD_EN only)
// ----------------------------------------------------------------------------
module uv_row_sse #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  localparam int RW        = BIT_WIDTH + 1,
  localparam int SSE_W     = 2 * BIT_WIDTH + $clog2(BLOCK_SIZE),
  localparam int SAD_W     = BIT_WIDTH + $clog2(BLOCK_SIZE)
) (
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] src_row,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] pred_row,
  output logic [RW*BLOCK_SIZE-1:0]        resid_row,
`ifdef UV_PRED_SAD_EN
  output logic [SAD_W-1:0]                row_sad,
`endif
  output logic [SSE_W-1:0]                row_sse
);

  logic [RW-1:0]   diff_s;
  logic [RW-1:0]   mag_s;
  logic [2*RW-1:0] sq_s;

  // Per-sample residual, magnitude and square, summed across the row.
  always_comb begin
    resid_row = '0;
    row_sse   = '0;
`ifdef UV_PRED_SAD_EN
    row_sad   = '0;
`endif
    diff_s    = '0;
    mag_s     = '0;
    sq_s      = '0;
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      // Zero-extend both samples so the RW-bit difference is exact two's complement.
      diff_s = {1'b0, src_row[c*BIT_WIDTH +: BIT_WIDTH]}
             - {1'b0, pred_row[c*BIT_WIDTH +: BIT_WIDTH]};
      if (diff_s[RW-1]) begin
        mag_s = ~diff_s + {{(RW-1){1'b0}}, 1'b1};
      end else begin
        mag_s = diff_s;
      end
      sq_s = {{RW{1'b0}}, mag_s} * {{RW{1'b0}}, mag_s};
      resid_row[c*RW +: RW] = diff_s;
      row_sse = row_sse + sq_s[SSE_W-1:0];
`ifdef UV_PRED_SAD_EN
      row_sad = row_sad + {{(SAD_W-RW){1'b0}}, mag_s};
`endif
    end
  end

endmodule

// File: rtl/uv_pred_sse.sv
// ----------------------------------------------------------------------------
// uv_pred_sse
// Chroma mode-decision stage. On an accepted start the 8x16 prediction and
// source blocks are latched; the 16 residual rows are then streamed over a
// valid/ready interface and the per-plane SSE is accumulated on each
// accepted row. done pulses once when sse_u/sse_v are final; they hold
// until the next accepted start.
// Optional feature macro: UV_PRED_SAD_EN adds sad_u/sad_v (sum of |resid|).
// Ports:
//   clk, rst_n   : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   start        : one-cycle request, honoured only in IDLE
//   pred, src    : blocks, row r at [64r +: 64], sample c at [8c +: 8]
//   rif (master) : resid_row / resid_idx / resid_valid / resid_ready
//   sse_u, sse_v : per-plane SSE
//   sad_u, sad_v : per-plane SAD (UV_PRED_SAD_EN only)
//   busy, done   : busy during the row stream, done one-cycle pulse
// ----------------------------------------------------------------------------
module uv_pred_sse
  import uv_pred_sse_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int UV_SIZE    = UV_SIZE_DEF,
  parameter int SSE_WIDTH  = SSE_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [BIT_WIDTH*BLOCK_SIZE*UV_SIZE-1:0] pred,
  input  logic [BIT_WIDTH*BLOCK_SIZE*UV_SIZE-1:0] src,
  uv_pred_sse_if.master                         rif,
  output logic [SSE_WIDTH-1:0]                  sse_u,
  output logic [SSE_WIDTH-1:0]                  sse_v,
`ifdef UV_PRED_SAD_EN
  output logic [BIT_WIDTH+6:0]                  sad_u,
  output logic [BIT_WIDTH+6:0]                  sad_v,
`endif
  output logic                                  busy,
  output logic                                  done
);

  localparam int ROW_W   = BIT_WIDTH * BLOCK_SIZE;
  localparam int RSSE_W  = 2 * BIT_WIDTH + $clog2(BLOCK_SIZE);
  localparam int RSAD_W  = BIT_WIDTH + $clog2(BLOCK_SIZE);
  localparam int SAD_W   = BIT_WIDTH + 7;

  state_t                 state_r;
  logic [3:0]             row_r;
  logic [ROW_W-1:0]       src_rows_r  [UV_SIZE];
  logic [ROW_W-1:0]       pred_rows_r [UV_SIZE];
  logic [SSE_WIDTH-1:0]   sse_u_r;
  logic [SSE_WIDTH-1:0]   sse_v_r;
  logic                   valid_r;
  logic                   busy_r;
  logic                   done_r;
  logic [RSSE_W-1:0]      row_sse_s;
`ifdef UV_PRED_SAD_EN
  logic [SAD_W-1:0]       sad_u_r;
  logic [SAD_W-1:0]       sad_v_r;
  logic [RSAD_W-1:0]      row_sad_s;
`endif

  // Residual row is combinational from the latched block and the row counter.
  uv_row_sse #(
    .BIT_WIDTH  (BIT_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_row (
    .src_row   (src_rows_r[row_r]),
    .pred_row  (pred_rows_r[row_r]),
    .resid_row (rif.resid_row),
`ifdef UV_PRED_SAD_EN
    .row_sad   (row_sad_s),
`endif
    .row_sse   (row_sse_s)
  );

  // FSM, input latches, row counter and per-plane accumulators.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      row_r   <= 4'd0;
      sse_u_r <= '0;
      sse_v_r <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef UV_PRED_SAD_EN
      sad_u_r <= '0;
      sad_v_r <= '0;
`endif
      for (int r = 0; r < UV_SIZE; r++) begin
        src_rows_r[r]  <= '0;
        pred_rows_r[r] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            for (int r = 0; r < UV_SIZE; r++) begin
              src_rows_r[r]  <= src[r*ROW_W +: ROW_W];
              pred_rows_r[r] <= pred[r*ROW_W +: ROW_W];
            end
            sse_u_r <= '0;
            sse_v_r <= '0;
`ifdef UV_PRED_SAD_EN
            sad_u_r <= '0;
            sad_v_r <= '0;
`endif
            row_r   <= 4'd0;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // valid is always high in RUN, so ready alone marks a handshake.
          if (rif.resid_ready) begin
            if (row_r < 4'(BLOCK_SIZE)) begin
              sse_u_r <= sse_u_r + SSE_WIDTH'(row_sse_s);
`ifdef UV_PRED_SAD_EN
              sad_u_r <= sad_u_r + SAD_W'(row_sad_s);
`endif
            end else begin
              sse_v_r <= sse_v_r + SSE_WIDTH'(row_sse_s);
`ifdef UV_PRED_SAD_EN
              sad_v_r <= sad_v_r + SAD_W'(row_sad_s);
`endif
            end
            row_r <= row_r + 4'd1;
            if (row_r == 4'(UV_SIZE - 1)) begin
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rif.resid_valid = valid_r;
  assign rif.resid_idx   = row_r;
  assign sse_u           = sse_u_r;
  assign sse_v           = sse_v_r;
  assign busy            = busy_r;
  assign done            = done_r;
`ifdef UV_PRED_SAD_EN
  assign sad_u           = sad_u_r;
  assign sad_v           = sad_v_r;
`endif

endmodule

// File: tb/tb_uv_pred_sse.sv
// ----------------------------------------------------------------------------
// tb_uv_pred_sse
// Self-checking bench: directed and random blocks are streamed with several
// resid_ready patterns; every row, index, control output and the final
// SSE (and SAD when UV_PRED_SAD_EN is defined) is compared against a
// reference computed from plain integer arithmetic on the sample arrays.
// ----------------------------------------------------------------------------
module tb_uv_pred_sse;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1023:0] pred;
  logic [1023:0] src;
  logic [21:0]   sse_u;
  logic [21:0]   sse_v;
  logic          busy;
  logic          done;
`ifdef UV_PRED_SAD_EN
  logic [14:0]   sad_u;
  logic [14:0]   sad_v;
`endif

  uv_pred_sse_if rif ();

  uv_pred_sse dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .pred  (pred),
    .src   (src),
    .rif   (rif),
    .sse_u (sse_u),
    .sse_v (sse_v),
`ifdef UV_PRED_SAD_EN
    .sad_u (sad_u),
    .sad_v (sad_v),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int src_a  [16][8];
  int pred_a [16][8];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: residual row k packed as 8 x 9-bit two's complement.
  function automatic logic [71:0] ref_row(input int k);
    logic [71:0] v;
    logic [31:0] d;
    v = '0;
    for (int c = 0; c < 8; c++) begin
      d = 32'(src_a[k][c] - pred_a[k][c]);
      v[9*c +: 9] = d[8:0];
    end
    return v;
  endfunction

  function automatic int ref_sse(input int plane);
    int s = 0;
    for (int r = 8*plane; r < 8*plane + 8; r++)
      for (int c = 0; c < 8; c++)
        s += (src_a[r][c] - pred_a[r][c]) * (src_a[r][c] - pred_a[r][c]);
    return s;
  endfunction

  function automatic int ref_sad(input int plane);
    int s = 0;
    int d;
    for (int r = 8*plane; r < 8*plane + 8; r++)
      for (int c = 0; c < 8; c++) begin
        d = src_a[r][c] - pred_a[r][c];
        s += (d < 0) ? -d : d;
      end
    return s;
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) begin
        case (pat)
          0: begin src_a[r][c] = 128; pred_a[r][c] = 128; end
          1: begin
            if (r < 8) begin src_a[r][c] = 255; pred_a[r][c] = 0; end
            else       begin src_a[r][c] = 16;  pred_a[r][c] = 16; end
          end
          2: begin src_a[r][c] = 0; pred_a[r][c] = 255; end
          3: begin src_a[r][c] = $urandom_range(0, 255); pred_a[r][c] = $urandom_range(0, 255); end
          default: begin
            src_a[r][c]  = ($urandom_range(0, 1) == 1) ? 255 : $urandom_range(0, 3);
            pred_a[r][c] = ($urandom_range(0, 1) == 1) ? 255 : $urandom_range(0, 3);
          end
        endcase
        src[64*r + 8*c +: 8]  = 8'(src_a[r][c]);
        pred[64*r + 8*c +: 8] = 8'(pred_a[r][c]);
      end
  endtask

  // Entered and left at a negedge. mode: 0 ready=1, 1 toggle from 0, 2 random.
  // poke: pulse start at cycle N+4 and in the DONE cycle (both must be ignored).
  task automatic run_block(input int pat, input int mode, input bit poke, input int exp_total);
    int k = 0;
    int n = 1;
    int stalls = 0;
    bit rdy;
    fill(pat);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // inputs may change freely after the start cycle
    src  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pred = ~src;
    while (k < 16 && n < 120) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (n % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rif.resid_ready = rdy;
      if (!rdy) stalls++;
      check_val("valid", 128'(rif.resid_valid), 128'(1));
      check_val("busy", 128'(busy), 128'(1));
      check_val("done_run", 128'(done), 128'(0));
      check_val("idx", 128'(rif.resid_idx), 128'(k));
      check_val("row", 128'(rif.resid_row), 128'(ref_row(k)));
      start = (poke && n == 4);
      @(posedge clk);
      if (rdy) k++;
      @(negedge clk);
      n++;
    end
    rif.resid_ready = 1'b1;
    check_val("row_budget", 128'(k), 128'(16));
    check_val("done_cycle", 128'(n), 128'(17 + stalls));
    if (exp_total > 0) check_val("done_latency", 128'(n), 128'(exp_total));
    check_val("done", 128'(done), 128'(1));
    check_val("busy_done", 128'(busy), 128'(0));
    check_val("valid_done", 128'(rif.resid_valid), 128'(0));
    check_val("sse_u", 128'(sse_u), 128'(ref_sse(0)));
    check_val("sse_v", 128'(sse_v), 128'(ref_sse(1)));
`ifdef UV_PRED_SAD_EN
    check_val("sad_u", 128'(sad_u), 128'(ref_sad(0)));
    check_val("sad_v", 128'(sad_v), 128'(ref_sad(1)));
`endif
    start = poke;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("done_pulse", 128'(done), 128'(0));
    check_val("busy_after", 128'(busy), 128'(0));
    check_val("valid_after", 128'(rif.resid_valid), 128'(0));
    check_val("sse_u_hold", 128'(sse_u), 128'(ref_sse(0)));
    check_val("sse_v_hold", 128'(sse_v), 128'(ref_sse(1)));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    src = '0;
    pred = '0;
    rif.resid_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_done", 128'(done), 128'(0));
    check_val("rst_valid", 128'(rif.resid_valid), 128'(0));
    check_val("rst_idx", 128'(rif.resid_idx), 128'(0));
    check_val("rst_row", 128'(rif.resid_row), 128'(0));
    check_val("rst_sse_u", 128'(sse_u), 128'(0));
    check_val("rst_sse_v", 128'(sse_v), 128'(0));

    run_block(0, 0, 1'b0, 17);
    run_block(1, 0, 1'b0, 17);
    run_block(2, 0, 1'b0, 17);
    run_block(0, 1, 1'b0, 33);
    run_block(3, 0, 1'b1, 17);
    run_block(4, 0, 1'b0, 17);   // launched in the cycle right after done

    // Reset in the middle of a block while row 5 is presented.
    fill(3);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rif.resid_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("mid_idx", 128'(rif.resid_idx), 128'(5));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check_val("mid_busy", 128'(busy), 128'(0));
    check_val("mid_valid", 128'(rif.resid_valid), 128'(0));
    check_val("mid_done", 128'(done), 128'(0));
    check_val("mid_sse_u", 128'(sse_u), 128'(0));
    check_val("mid_sse_v", 128'(sse_v), 128'(0));
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_block((i % 2 == 0) ? 3 : 4, 2, 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
